sprite_line_renderer: RTL

- Upstream pixel source feeding the FSX colour mux in parallel with BGWrenderer; output is overlaid onto BGW_r/g/b when opaque.
- During each display line, scans the sprite attribute table in VRAMSPR and composes the next line into a ping-pong line buffer.
- Presents the current line's sprite pixel and opaque flag per pixel coordinate.

---
 rtl/sprite_pkg.sv | 46 ++++
 rtl/sprite_line_renderer_if.sv | 8 +
 rtl/sprite_line_renderer_line_buffer.sv | 67 ++++++
 rtl/sprite_line_renderer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line renderer: FSM states,
// attribute/pattern layout and address helpers.
package sprite_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_Y  = 4'd1,
    S_CHK_Y = 4'd2,
    S_RD_X  = 4'd3,
    S_RD_T  = 4'd4,
    S_RD_A  = 4'd5,
    S_CHK_A = 4'd6,
    S_FETCH = 4'd7,
    S_WRITE = 4'd8,
    S_NEXT  = 4'd9,
    S_DONE  = 4'd10
  } state_e;

  localparam logic [1:0] ATTR_Y     = 2'd0;
  localparam logic [1:0] ATTR_X     = 2'd1;
  localparam logic [1:0] ATTR_TILE  = 2'd2;
  localparam logic [1:0] ATTR_FLAGS = 2'd3;

  localparam int FLAG_EN    = 0;
  localparam int FLAG_HFLIP = 1;
  localparam int FLAG_VFLIP = 2;
  localparam int PAT_OPAQUE = 8;

  localparam int SPR_SIZE = 8;
  localparam int LINE_W   = 512;
  localparam int RGB_W    = 8;
  localparam int RGB_R_W  = 3;
  localparam int RGB_G_W  = 3;
  localparam int RGB_B_W  = 2;

  function automatic logic [13:0] attr_addr(input logic [5:0] idx, input logic [1:0] off);
    return {6'd0, idx, off};
  endfunction

  // Pattern word for (tile,row,col); the tile*64+row*8+col offset is a plain concatenation.
  function automatic logic [13:0] pat_addr(input logic [13:0] base, input logic [6:0] tile,
                                           input logic [2:0] row, input logic [2:0] col);
    return base + {1'b0, tile, row, col};
  endfunction

endpackage

// File: rtl/sprite_line_renderer_if.sv
// VRAMSPR read bus: registered address out, data back one clock later.
interface sprite_vram_if;
  logic [13:0] vramSPR_addr;
  logic [8:0]  vramSPR_q;

  modport master (output vramSPR_addr, input vramSPR_q);
  modport slave  (input vramSPR_addr, output vramSPR_q);
endinterface

// File: rtl/sprite_line_renderer_line_buffer.sv
// Ping-pong sprite line buffer: two 512x8 banks with per-pixel occupancy,
// a registered display read port and a compose write/occupancy-read port.
module sprite_line_buffer
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             swap,
  input  logic [8:0]       disp_x,
  output logic [RGB_W-1:0] disp_rgb_r,
  output logic             disp_opaque_r,
  input  logic [8:0]       cmp_x,
  input  logic             cmp_we,
  input  logic [RGB_W-1:0] cmp_rgb,
  output logic             cmp_occ_s
);

  logic             sel_r;
  logic [RGB_W-1:0] ram0_r [0:LINE_W-1];
  logic [RGB_W-1:0] ram1_r [0:LINE_W-1];
  logic [LINE_W-1:0] occ0_r;
  logic [LINE_W-1:0] occ1_r;

  // Bank select toggles on swap; the bank leaving display is cleared to become the compose bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r  <= 1'b0;
      occ0_r <= '0;
      occ1_r <= '0;
    end else if (swap) begin
      sel_r <= ~sel_r;
      if (sel_r) occ1_r <= '0;
      else       occ0_r <= '0;
    end else if (cmp_we) begin
      if (sel_r) occ0_r[cmp_x] <= 1'b1;
      else       occ1_r[cmp_x] <= 1'b1;
    end
  end

  // Compose-bank pixel data write.
  always_ff @(posedge clk) begin
    if (cmp_we) begin
      if (sel_r) ram0_r[cmp_x] <= cmp_rgb;
      else       ram1_r[cmp_x] <= cmp_rgb;
    end
  end

  // Occupancy of the compose bank at the pixel being written.
  always_comb begin
    cmp_occ_s = sel_r ? occ0_r[cmp_x] : occ1_r[cmp_x];
  end

  // Registered display read; colour forced to 0 where no sprite pixel exists.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_rgb_r    <= '0;
      disp_opaque_r <= 1'b0;
    end else if (sel_r) begin
      disp_opaque_r <= occ1_r[disp_x];
      disp_rgb_r    <= occ1_r[disp_x] ? ram1_r[disp_x] : 8'h00;
    end else begin
      disp_opaque_r <= occ0_r[disp_x];
      disp_rgb_r    <= occ0_r[disp_x] ? ram0_r[disp_x] : 8'h00;
    end
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: scans the attribute table each line and composes the
// next line into a ping-pong buffer while the current line is displayed.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES  = 64,
  parameter int          MAX_PER_LINE = 16,
  parameter logic [13:0] PAT_BASE     = 14'h0400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [8:0]       next_y,
  input  logic [8:0]       pix_x,
  sprite_vram_if.master    vram,
  output logic [RGB_W-1:0] spr_rgb,
  output logic             spr_opaque,
  output logic             spr_overflow,
  output logic             busy
);

  state_e      state_r;
  logic [13:0] addr_r;
  logic [8:0]  ty_r;
  logic [5:0]  idx_r;
  logic [6:0]  count_r;
  logic [2:0]  dy_r;
  logic [8:0]  x_r;
  logic [6:0]  tile_r;
  logic [2:0]  row_r;
  logic        hflip_r;
  logic [2:0]  c_r;
  logic        overflow_r;
  logic        busy_r;

  logic [8:0]  dy_s;
  logic [2:0]  row_s;
  logic [2:0]  col_next_s;
  logic        wr_phase_s;
  logic [8:0]  wr_x_s;
  logic        cmp_we_s;
  logic        cmp_occ_s;

  assign vram.vramSPR_addr = addr_r;
  assign spr_overflow      = overflow_r;
  assign busy              = busy_r;

  // Pixel write lags its pattern fetch by one clock, so the column in flight is c_r-1.
  always_comb begin
    dy_s       = ty_r - vram.vramSPR_q;
    row_s      = vram.vramSPR_q[FLAG_VFLIP] ? ~dy_r : dy_r;
    col_next_s = (c_r + 3'd1) ^ {3{hflip_r}};
    wr_phase_s = ((state_r == S_FETCH) && (c_r != 3'd0)) || (state_r == S_WRITE);
    wr_x_s     = x_r + {6'd0, c_r - 3'd1};
    cmp_we_s   = wr_phase_s && vram.vramSPR_q[PAT_OPAQUE] && !cmp_occ_s && !line_start;
  end

  // Composition FSM; line_start overrides any state and restarts the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      addr_r     <= 14'd0;
      ty_r       <= 9'd0;
      idx_r      <= 6'd0;
      count_r    <= 7'd0;
      dy_r       <= 3'd0;
      x_r        <= 9'd0;
      tile_r     <= 7'd0;
      row_r      <= 3'd0;
      hflip_r    <= 1'b0;
      c_r        <= 3'd0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (frame_start) overflow_r <= 1'b0;
      if (line_start) begin
        if (busy_r) overflow_r <= 1'b1;
        state_r <= S_RD_Y;
        busy_r  <= 1'b1;
        ty_r    <= next_y;
        idx_r   <= 6'd0;
        count_r <= 7'd0;
        c_r     <= 3'd0;
        addr_r  <= attr_addr(6'd0, ATTR_Y);
      end else begin
        case (state_r)
          S_IDLE: state_r <= S_IDLE;
          S_RD_Y: state_r <= S_CHK_Y;
          S_CHK_Y: begin
            if (dy_s < 9'(SPR_SIZE)) begin
              dy_r    <= dy_s[2:0];
              addr_r  <= attr_addr(idx_r, ATTR_X);
              state_r <= S_RD_X;
            end else begin
              state_r <= S_NEXT;
            end
          end
          S_RD_X: begin
            addr_r  <= attr_addr(idx_r, ATTR_TILE);
            state_r <= S_RD_T;
          end
          S_RD_T: begin
            x_r     <= vram.vramSPR_q;
            addr_r  <= attr_addr(idx_r, ATTR_FLAGS);
            state_r <= S_RD_A;
          end
          S_RD_A: begin
            tile_r  <= vram.vramSPR_q[6:0];
            state_r <= S_CHK_A;
          end
          S_CHK_A: begin
            if (!vram.vramSPR_q[FLAG_EN]) begin
              state_r <= S_NEXT;
            end else if (count_r == 7'(MAX_PER_LINE)) begin
              overflow_r <= 1'b1;
              state_r    <= S_DONE;
            end else begin
              count_r <= count_r + 7'd1;
              row_r   <= row_s;
              hflip_r <= vram.vramSPR_q[FLAG_HFLIP];
              c_r     <= 3'd0;
              addr_r  <= pat_addr(PAT_BASE, tile_r, row_s, {3{vram.vramSPR_q[FLAG_HFLIP]}});
              state_r <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (c_r == 3'(SPR_SIZE - 1)) begin
              c_r     <= 3'd0;
              state_r <= S_WRITE;
            end else begin
              c_r    <= c_r + 3'd1;
              addr_r <= pat_addr(PAT_BASE, tile_r, row_r, col_next_s);
            end
          end
          S_WRITE: state_r <= S_NEXT;
          S_NEXT: begin
            if (idx_r == 6'(NUM_SPRITES - 1)) begin
              state_r <= S_DONE;
            end else begin
              idx_r   <= idx_r + 6'd1;
              addr_r  <= attr_addr(idx_r + 6'd1, ATTR_Y);
              state_r <= S_RD_Y;
            end
          end
          S_DONE: begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

  sprite_line_buffer u_buf (
    .clk           (clk),
    .reset         (reset),
    .swap          (line_start),
    .disp_x        (pix_x),
    .disp_rgb_r    (spr_rgb),
    .disp_opaque_r (spr_opaque),
    .cmp_x         (wr_x_s),
    .cmp_we        (cmp_we_s),
    .cmp_rgb       (vram.vramSPR_q[7:0]),
    .cmp_occ_s     (cmp_occ_s)
  );

endmodule
